// File: rtl/keeper_ctl.sv
// Goalkeeper motion controller: after a shot, waits a reaction delay, slides to the
// dive target, holds, then returns home. Position only moves on the vblnk rising edge.
module keeper_ctl #(
  parameter int X_CENTER     = 412,
  parameter int X_MIN        = 0,
  parameter int X_MAX        = 824,
  parameter int SPEED        = 8,
  parameter int REACT_FRAMES = 10,
  parameter int HOLD_FRAMES  = 60
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       vblnk,
  input  logic       shot,
  input  logic [9:0] target_x,
  output logic [9:0] keeper_x_pos,
  output logic       busy,
  output logic       save_done
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_REACT  = 3'd1;
  localparam logic [2:0] S_MOVE   = 3'd2;
  localparam logic [2:0] S_HOLD   = 3'd3;
  localparam logic [2:0] S_RETURN = 3'd4;

  localparam int CNT_MAX = (REACT_FRAMES > HOLD_FRAMES) ? REACT_FRAMES : HOLD_FRAMES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0]   REACT_LAST = CNT_W'(REACT_FRAMES - 1);
  localparam logic [CNT_W-1:0]   HOLD_LAST  = CNT_W'(HOLD_FRAMES - 1);
  localparam logic [CNT_W-1:0]   CNT_ONE    = CNT_W'(1);
  localparam logic [9:0]         XC_V       = 10'(X_CENTER);
  localparam logic [9:0]         XMIN_V     = 10'(X_MIN);
  localparam logic [9:0]         XMAX_V     = 10'(X_MAX);
  localparam logic [9:0]         SPEED_V    = 10'(SPEED);
  localparam logic signed [10:0] XMIN_S     = 11'(X_MIN);
  localparam logic signed [10:0] XMAX_S     = 11'(X_MAX);
  localparam logic signed [10:0] SPEED_S    = 11'(SPEED);

  logic [2:0]       r_state;
  logic             r_vblnk_q;
  logic [9:0]       r_tgt;
  logic [9:0]       r_pos;
  logic [CNT_W-1:0] r_cnt;
  logic             r_busy;
  logic             r_save_done;

  logic                w_tick;
  logic signed [10:0]  w_tgt_s;
  logic [9:0]          w_tgt_clamped;
  logic [9:0]          w_goal;
  logic signed [10:0]  w_diff;
  logic signed [10:0]  w_abs;
  logic                w_arrive;
  logic [9:0]          w_step_pos;

  assign w_tick = vblnk & ~r_vblnk_q;

  // Signed 11-bit compare so out-of-range targets clamp without wrap.
  always_comb begin
    w_tgt_s       = $signed({1'b0, target_x});
    w_tgt_clamped = target_x;
    if (w_tgt_s > XMAX_S) begin
      w_tgt_clamped = XMAX_V;
    end else if (w_tgt_s < XMIN_S) begin
      w_tgt_clamped = XMIN_V;
    end
  end

  // Shared stepper for MOVE and RETURN: full SPEED step unless within reach of the goal.
  always_comb begin
    w_goal   = (r_state == S_RETURN) ? XC_V : r_tgt;
    w_diff   = $signed({1'b0, w_goal}) - $signed({1'b0, r_pos});
    w_abs    = w_diff[10] ? -w_diff : w_diff;
    w_arrive = (w_abs <= SPEED_S);
    if (w_arrive) begin
      w_step_pos = w_goal;
    end else if (w_diff[10]) begin
      w_step_pos = r_pos - SPEED_V;
    end else begin
      w_step_pos = r_pos + SPEED_V;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_vblnk_q   <= 1'b0;
      r_tgt       <= XC_V;
      r_pos       <= XC_V;
      r_cnt       <= '0;
      r_busy      <= 1'b0;
      r_save_done <= 1'b0;
    end else begin
      r_vblnk_q   <= vblnk;
      r_save_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (shot) begin
            r_state <= S_REACT;
            r_tgt   <= w_tgt_clamped;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
          end
        end
        S_REACT: begin
          if (w_tick) begin
            if (r_cnt == REACT_LAST) begin
              r_state <= S_MOVE;
              r_cnt   <= '0;
            end else begin
              r_cnt <= r_cnt + CNT_ONE;
            end
          end
        end
        S_MOVE: begin
          if (w_tick) begin
            r_pos <= w_step_pos;
            if (w_arrive) begin
              r_state <= S_HOLD;
              r_cnt   <= '0;
            end
          end
        end
        S_HOLD: begin
          if (w_tick) begin
            if (r_cnt == HOLD_LAST) begin
              r_state <= S_RETURN;
              r_cnt   <= '0;
            end else begin
              r_cnt <= r_cnt + CNT_ONE;
            end
          end
        end
        S_RETURN: begin
          if (w_tick) begin
            r_pos <= w_step_pos;
            if (w_arrive) begin
              r_state     <= S_IDLE;
              r_busy      <= 1'b0;
              r_save_done <= 1'b1;
            end
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign keeper_x_pos = r_pos;
  assign busy         = r_busy;
  assign save_done    = r_save_done;

endmodule

// File: tb/tb_keeper_ctl.sv
// Directed bench for keeper_ctl: short synthetic frames (vblnk high 2 clks, low 4 clks).
module tb_keeper_ctl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       vblnk = 1'b0;
  logic       shot = 1'b0;
  logic [9:0] target_x = 10'd0;
  logic [9:0] keeper_x_pos;
  logic       busy;
  logic       save_done;

  int n_cmp = 0;
  int n_err = 0;
  int sd_count = 0;
  int pos_viol = 0;
  int range_viol = 0;

  logic       tb_vq = 1'b0;
  logic       tb_tick_q = 1'b0;
  logic       tb_rst_q = 1'b0;
  logic [9:0] last_pos = 10'd412;

  keeper_ctl dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .vblnk        (vblnk),
    .shot         (shot),
    .target_x     (target_x),
    .keeper_x_pos (keeper_x_pos),
    .busy         (busy),
    .save_done    (save_done)
  );

  always #5 clk = ~clk;

  // Independent frame-tick reference, used to catch position changes off the tick.
  always @(posedge clk) begin
    tb_tick_q <= rst_n & vblnk & ~tb_vq;
    tb_vq     <= rst_n ? vblnk : 1'b0;
    tb_rst_q  <= rst_n;
  end

  always @(negedge clk) begin
    if (tb_rst_q && !tb_tick_q && keeper_x_pos !== last_pos) pos_viol <= pos_viol + 1;
    if (keeper_x_pos > 10'd824) range_viol <= range_viol + 1;
    if (save_done === 1'b1) sd_count <= sd_count + 1;
    last_pos <= keeper_x_pos;
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic frames(input int n);
    repeat (n) begin
      vblnk = 1'b1;
      cyc(2);
      vblnk = 1'b0;
      cyc(4);
    end
  endtask

  task automatic fire(input logic [9:0] tx);
    shot = 1'b1;
    target_x = tx;
    cyc(1);
    shot = 1'b0;
    cyc(1);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    cyc(2);
    rst_n = 1'b1;
    cyc(1);
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++; if (keeper_x_pos !== 10'd412) begin n_err++; $display("FAIL reset_pos: got %0d want 412", keeper_x_pos); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_cmp++; if (save_done !== 1'b0) begin n_err++; $display("FAIL reset_save_done: got %b want 0", save_done); end
    frames(5);
    n_cmp++; if (keeper_x_pos !== 10'd412) begin n_err++; $display("FAIL idle_pos: got %0d want 412", keeper_x_pos); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL idle_busy: got %b want 0", busy); end
    n_cmp++; if (sd_count !== 0) begin n_err++; $display("FAIL idle_no_save_done: got %0d pulses want 0", sd_count); end
    $display("test_reset done");
  endtask

  task automatic test_save_left();
    int sd0;
    sd0 = sd_count;
    fire(10'd100);
    n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL shot_busy: got %b want 1", busy); end
    frames(10);
    n_cmp++; if (keeper_x_pos !== 10'd412) begin n_err++; $display("FAIL react_pos: got %0d want 412", keeper_x_pos); end
    frames(1);
    n_cmp++; if (keeper_x_pos !== 10'd404) begin n_err++; $display("FAIL move1_pos: got %0d want 404", keeper_x_pos); end
    frames(1);
    n_cmp++; if (keeper_x_pos !== 10'd396) begin n_err++; $display("FAIL move2_pos: got %0d want 396", keeper_x_pos); end
    frames(36);
    n_cmp++; if (keeper_x_pos !== 10'd108) begin n_err++; $display("FAIL move38_pos: got %0d want 108", keeper_x_pos); end
    frames(1);
    n_cmp++; if (keeper_x_pos !== 10'd100) begin n_err++; $display("FAIL move39_pos: got %0d want 100", keeper_x_pos); end
    frames(60);
    n_cmp++; if (keeper_x_pos !== 10'd100) begin n_err++; $display("FAIL hold_pos: got %0d want 100", keeper_x_pos); end
    n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL hold_busy: got %b want 1", busy); end
    frames(38);
    n_cmp++; if (keeper_x_pos !== 10'd404) begin n_err++; $display("FAIL ret38_pos: got %0d want 404", keeper_x_pos); end
    n_cmp++; if (sd_count !== sd0) begin n_err++; $display("FAIL ret_early_done: got %0d pulses want %0d", sd_count, sd0); end
    frames(1);
    n_cmp++; if (keeper_x_pos !== 10'd412) begin n_err++; $display("FAIL ret_home_pos: got %0d want 412", keeper_x_pos); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL ret_home_busy: got %b want 0", busy); end
    n_cmp++; if (sd_count !== sd0 + 1) begin n_err++; $display("FAIL save_done_pulse: got %0d pulses want %0d", sd_count, sd0 + 1); end
    $display("test_save_left done");
  endtask

  task automatic test_clamp_and_nomove();
    int sd0;
    sd0 = sd_count;
    fire(10'd1000);
    frames(10 + 51);
    n_cmp++; if (keeper_x_pos !== 10'd820) begin n_err++; $display("FAIL clamp_step51: got %0d want 820", keeper_x_pos); end
    frames(1);
    n_cmp++; if (keeper_x_pos !== 10'd824) begin n_err++; $display("FAIL clamp_arrive: got %0d want 824", keeper_x_pos); end
    frames(60);
    n_cmp++; if (keeper_x_pos !== 10'd824) begin n_err++; $display("FAIL clamp_hold: got %0d want 824", keeper_x_pos); end
    frames(51);
    n_cmp++; if (keeper_x_pos !== 10'd416) begin n_err++; $display("FAIL clamp_ret51: got %0d want 416", keeper_x_pos); end
    n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL clamp_ret_busy: got %b want 1", busy); end
    frames(1);
    n_cmp++; if (keeper_x_pos !== 10'd412) begin n_err++; $display("FAIL clamp_ret_home: got %0d want 412", keeper_x_pos); end
    n_cmp++; if (sd_count !== sd0 + 1) begin n_err++; $display("FAIL clamp_done: got %0d pulses want %0d", sd_count, sd0 + 1); end
    n_cmp++; if (range_viol !== 0) begin n_err++; $display("FAIL clamp_range: got %0d overshoots want 0", range_viol); end
    fire(10'd412);
    frames(11);
    n_cmp++; if (keeper_x_pos !== 10'd412) begin n_err++; $display("FAIL nomove_pos: got %0d want 412", keeper_x_pos); end
    frames(60);
    n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL nomove_hold_busy: got %b want 1", busy); end
    frames(1);
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL nomove_ret_busy: got %b want 0", busy); end
    n_cmp++; if (sd_count !== sd0 + 2) begin n_err++; $display("FAIL nomove_done: got %0d pulses want %0d", sd_count, sd0 + 2); end
    $display("test_clamp_and_nomove done");
  endtask

  task automatic test_shot_rules();
    fire(10'd200);
    frames(12);
    fire(10'd700);
    frames(1);
    n_cmp++; if (keeper_x_pos !== 10'd388) begin n_err++; $display("FAIL ignore_step: got %0d want 388", keeper_x_pos); end
    frames(24);
    n_cmp++; if (keeper_x_pos !== 10'd200) begin n_err++; $display("FAIL ignore_arrive: got %0d want 200", keeper_x_pos); end
    frames(1);
    n_cmp++; if (keeper_x_pos !== 10'd200) begin n_err++; $display("FAIL ignore_hold: got %0d want 200", keeper_x_pos); end
    do_reset();
    // Shot lands on the same cycle as a frame tick.
    vblnk = 1'b1;
    shot = 1'b1;
    target_x = 10'd100;
    cyc(1);
    shot = 1'b0;
    cyc(1);
    vblnk = 1'b0;
    cyc(4);
    n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL coinc_busy: got %b want 1", busy); end
    frames(10);
    n_cmp++; if (keeper_x_pos !== 10'd412) begin n_err++; $display("FAIL coinc_react: got %0d want 412", keeper_x_pos); end
    frames(1);
    n_cmp++; if (keeper_x_pos !== 10'd404) begin n_err++; $display("FAIL coinc_move: got %0d want 404", keeper_x_pos); end
    do_reset();
    $display("test_shot_rules done");
  endtask

  task automatic test_reset_mid_save();
    int sd0;
    sd0 = sd_count;
    fire(10'd100);
    frames(10 + 39 + 5);
    n_cmp++; if (keeper_x_pos !== 10'd100) begin n_err++; $display("FAIL mid_hold_pos: got %0d want 100", keeper_x_pos); end
    rst_n = 1'b0;
    cyc(1);
    n_cmp++; if (keeper_x_pos !== 10'd412) begin n_err++; $display("FAIL mid_rst_pos: got %0d want 412", keeper_x_pos); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL mid_rst_busy: got %b want 0", busy); end
    rst_n = 1'b1;
    frames(3);
    n_cmp++; if (sd_count !== sd0) begin n_err++; $display("FAIL mid_rst_no_done: got %0d pulses want %0d", sd_count, sd0); end
    n_cmp++; if (keeper_x_pos !== 10'd412) begin n_err++; $display("FAIL mid_rst_idle_pos: got %0d want 412", keeper_x_pos); end
    fire(10'd404);
    n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL mid_rst_reshot: got %b want 1", busy); end
    frames(11);
    n_cmp++; if (keeper_x_pos !== 10'd404) begin n_err++; $display("FAIL mid_rst_move: got %0d want 404", keeper_x_pos); end
    do_reset();
    $display("test_reset_mid_save done");
  endtask

  task automatic test_long_vblank();
    int moved;
    moved = 0;
    fire(10'd100);
    vblnk = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      cyc(1);
      if (keeper_x_pos !== 10'd412) moved++;
    end
    vblnk = 1'b0;
    cyc(4);
    n_cmp++; if (moved !== 0) begin n_err++; $display("FAIL long_vblank_still: got %0d moved cycles want 0", moved); end
    frames(9);
    n_cmp++; if (keeper_x_pos !== 10'd412) begin n_err++; $display("FAIL long_vblank_react: got %0d want 412", keeper_x_pos); end
    frames(1);
    n_cmp++; if (keeper_x_pos !== 10'd404) begin n_err++; $display("FAIL long_vblank_move: got %0d want 404", keeper_x_pos); end
    n_cmp++; if (pos_viol !== 0) begin n_err++; $display("FAIL pos_off_tick: got %0d changes want 0", pos_viol); end
    do_reset();
    $display("test_long_vblank done");
  endtask

  initial begin
    test_reset();
    test_save_left();
    test_clamp_and_nomove();
    test_shot_rules();
    test_reset_mid_save();
    test_long_vblank();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
